// File: rtl/oled_ctrl.sv
// rtl/oled_ctrl.sv - SSD1306 OLED reset/init/refresh sequencer over a 10-bit SPI byte transmitter
module oled_ctrl #(
    parameter int RES_LOW_CYCLES  = 250,
    parameter int RES_WAIT_CYCLES = 2500
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       FLUSH,
    output logic [9:0] FB_ADDR,
    input  logic [7:0] FB_RDATA,
    output logic [9:0] SPI_DATA,
    output logic       SPI_START,
    input  logic       SPI_DONE,
    output logic       OLED_RES,
    output logic       INIT_DONE,
    output logic       BUSY
);
    localparam logic [2:0] ST_RST_LOW   = 3'd0;
    localparam logic [2:0] ST_RST_WAIT  = 3'd1;
    localparam logic [2:0] ST_INIT      = 3'd2;
    localparam logic [2:0] ST_IDLE      = 3'd3;
    localparam logic [2:0] ST_PAGE_CMD  = 3'd4;
    localparam logic [2:0] ST_PAGE_RD   = 3'd5;
    localparam logic [2:0] ST_PAGE_DATA = 3'd6;

    localparam int CNT_MAX = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RES_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RES_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_idx;
    logic [1:0]       r_cidx;
    logic [1:0]       r_rd;
    logic [2:0]       r_page;
    logic [6:0]       r_col;
    logic [7:0]       r_byte;
    logic             r_wait;
    logic             r_pending;
    logic [9:0]       r_fb_addr;
    logic [9:0]       r_spi_data;
    logic             r_spi_start;
    logic             r_oled_res;
    logic             r_init_done;

    logic             w_sending;
    logic             w_byte_done;
    logic             w_tx_dc;
    logic [7:0]       w_tx_byte;

    function automatic logic [7:0] init_byte(input logic [4:0] idx);
        case (idx)
            5'd0:  init_byte = 8'hAE;
            5'd1:  init_byte = 8'hD5;
            5'd2:  init_byte = 8'h80;
            5'd3:  init_byte = 8'hA8;
            5'd4:  init_byte = 8'h3F;
            5'd5:  init_byte = 8'hD3;
            5'd6:  init_byte = 8'h00;
            5'd7:  init_byte = 8'h40;
            5'd8:  init_byte = 8'h8D;
            5'd9:  init_byte = 8'h14;
            5'd10: init_byte = 8'h20;
            5'd11: init_byte = 8'h02;
            5'd12: init_byte = 8'hA1;
            5'd13: init_byte = 8'hC8;
            5'd14: init_byte = 8'hDA;
            5'd15: init_byte = 8'h12;
            5'd16: init_byte = 8'h81;
            5'd17: init_byte = 8'hCF;
            5'd18: init_byte = 8'hD9;
            5'd19: init_byte = 8'hF1;
            5'd20: init_byte = 8'hDB;
            5'd21: init_byte = 8'h40;
            5'd22: init_byte = 8'hA4;
            5'd23: init_byte = 8'hA6;
            default: init_byte = 8'hAF;
        endcase
    endfunction

    assign w_sending   = (r_state == ST_INIT) || (r_state == ST_PAGE_CMD) || (r_state == ST_PAGE_DATA);
    assign w_byte_done = w_sending && r_wait && SPI_DONE;

    // Select the byte the current sending state wants on the wire (DC=0 command, DC=1 pixel data)
    always_comb begin
        w_tx_dc   = 1'b0;
        w_tx_byte = 8'h00;
        case (r_state)
            ST_INIT:      w_tx_byte = init_byte(r_idx);
            ST_PAGE_CMD: begin
                case (r_cidx)
                    2'd0:    w_tx_byte = {5'b10110, r_page};
                    2'd1:    w_tx_byte = 8'h00;
                    default: w_tx_byte = 8'h10;
                endcase
            end
            ST_PAGE_DATA: begin
                w_tx_dc   = 1'b1;
                w_tx_byte = r_byte;
            end
            default: ;
        endcase
    end

    // Main sequencer: panel reset timing, init stream, page refresh and the START/DONE handshake
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_RST_LOW;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_cidx      <= '0;
            r_rd        <= '0;
            r_page      <= '0;
            r_col       <= '0;
            r_byte      <= '0;
            r_wait      <= 1'b0;
            r_pending   <= 1'b0;
            r_fb_addr   <= '0;
            r_spi_data  <= 10'h3FF;
            r_spi_start <= 1'b0;
            r_oled_res  <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_spi_start <= 1'b0;
            if (FLUSH && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end
            // Launch a byte once per handshake; data then holds until DONE releases r_wait
            if (w_sending && !r_wait) begin
                r_spi_data  <= {1'b0, w_tx_dc, w_tx_byte};
                r_spi_start <= 1'b1;
                r_wait      <= 1'b1;
            end
            if (w_byte_done) begin
                r_wait <= 1'b0;
            end
            case (r_state)
                ST_RST_LOW: begin
                    if (r_cnt == LOW_LAST) begin
                        r_cnt      <= '0;
                        r_oled_res <= 1'b1;
                        r_state    <= ST_RST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_RST_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= ST_INIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_INIT: begin
                    if (w_byte_done) begin
                        if (r_idx == 5'd24) begin
                            r_init_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (FLUSH || r_pending) begin
                        r_pending <= 1'b0;
                        r_page    <= '0;
                        r_col     <= '0;
                        r_cidx    <= '0;
                        r_state   <= ST_PAGE_CMD;
                    end
                end
                ST_PAGE_CMD: begin
                    if (w_byte_done) begin
                        if (r_cidx == 2'd2) begin
                            r_cidx  <= '0;
                            r_rd    <= '0;
                            r_state <= ST_PAGE_RD;
                        end else begin
                            r_cidx <= r_cidx + 2'd1;
                        end
                    end
                end
                ST_PAGE_RD: begin
                    // Address out, one cycle for the synchronous RAM, then capture
                    case (r_rd)
                        2'd0: begin
                            r_fb_addr <= {r_page, r_col};
                            r_rd      <= 2'd1;
                        end
                        2'd1: r_rd <= 2'd2;
                        default: begin
                            r_byte  <= FB_RDATA;
                            r_rd    <= 2'd0;
                            r_state <= ST_PAGE_DATA;
                        end
                    endcase
                end
                ST_PAGE_DATA: begin
                    if (w_byte_done) begin
                        if (r_col == 7'd127) begin
                            r_col  <= '0;
                            r_page <= r_page + 3'd1;
                            r_cidx <= '0;
                            r_state <= (r_page == 3'd7) ? ST_IDLE : ST_PAGE_CMD;
                        end else begin
                            r_col   <= r_col + 7'd1;
                            r_state <= ST_PAGE_RD;
                        end
                    end
                end
                default: r_state <= ST_RST_LOW;
            endcase
        end
    end

    assign FB_ADDR   = r_fb_addr;
    assign SPI_DATA  = r_spi_data;
    assign SPI_START = r_spi_start;
    assign OLED_RES  = r_oled_res;
    assign INIT_DONE = r_init_done;
    assign BUSY      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_oled_ctrl.sv
// tb/tb_oled_ctrl.sv - directed vector bench for oled_ctrl
module tb_oled_ctrl;
    localparam int LOW  = 4;
    localparam int WAIT = 6;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       FLUSH = 1'b0;
    logic [9:0] FB_ADDR;
    logic [7:0] FB_RDATA = 8'h00;
    logic [9:0] SPI_DATA;
    logic       SPI_START;
    logic       OLED_RES;
    logic       INIT_DONE;
    logic       BUSY;
    logic       model_done = 1'b0;
    logic       force_done = 1'b0;
    wire        SPI_DONE = model_done | force_done;

    oled_ctrl #(.RES_LOW_CYCLES(LOW), .RES_WAIT_CYCLES(WAIT)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .FB_ADDR(FB_ADDR), .FB_RDATA(FB_RDATA),
        .SPI_DATA(SPI_DATA), .SPI_START(SPI_START), .SPI_DONE(SPI_DONE),
        .OLED_RES(OLED_RES), .INIT_DONE(INIT_DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Synchronous frame-buffer RAM whose content is the low byte of its own address
    always @(posedge CLK) FB_RDATA <= FB_ADDR[7:0];

    typedef struct {
        string      name;
        int         phase;
        int         idx;
        logic [9:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] init_tab [25];
    logic [9:0] log_q[$];
    logic [9:0] hold_word = '0;
    int         lat = 5;
    int         cd = 0;
    int         done_cnt = 0;
    int         stab_err = 0;
    int         proto_err = 0;
    int         n_vec = 0;
    int         n_err = 0;

    // SPI transmitter model: logs each START word, answers DONE after lat cycles, polices the handshake
    always @(negedge CLK) begin
        if (!RST_N) begin
            cd = 0;
            model_done = 1'b0;
        end else begin
            model_done = 1'b0;
            if (cd > 0) begin
                if (SPI_DATA !== hold_word) stab_err++;
                cd--;
                if (cd == 0) begin
                    model_done = 1'b1;
                    done_cnt++;
                end
            end
            if (SPI_START) begin
                if (cd > 0 || model_done) proto_err++;
                log_q.push_back(SPI_DATA);
                hold_word = SPI_DATA;
                cd = lat;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_vecs(input int phase);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].phase == phase) begin
                chk(vecs[i].name, (vecs[i].idx < log_q.size()) ? {22'd0, log_q[vecs[i].idx]} : 32'hFFFF_FFFF,
                    {22'd0, vecs[i].exp});
            end
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_oled_res", OLED_RES, 0);
        chk("rst_spi_start", SPI_START, 0);
        chk("rst_spi_data", SPI_DATA, 10'h3FF);
        chk("rst_fb_addr", FB_ADDR, 0);
        chk("rst_init_done", INIT_DONE, 0);
        chk("rst_busy", BUSY, 1);
        repeat (3) @(posedge CLK);
        log_q.delete();
        done_cnt = 0;
        #2 RST_N = 1'b1;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (log_q.size() < n) chk({name, "_timeout"}, log_q.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (BUSY !== 1'b0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (BUSY !== 1'b0) chk({name, "_timeout"}, BUSY, 0);
    endtask

    task automatic wait_init(input int budget);
        int   k = 0;
        logic prev_busy = 1'b0;
        while (INIT_DONE !== 1'b1 && k < budget) begin
            prev_busy = BUSY;
            @(negedge CLK);
            k++;
        end
        chk("init_done_rise", INIT_DONE, 1);
        chk("busy_before_init_done", prev_busy, 1);
        chk("busy_with_init_done", BUSY, 0);
        chk("init_done_count", done_cnt, 25);
    endtask

    task automatic pulse_flush();
        @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
    endtask

    initial begin
        int         lo;
        int         hi;
        int         bad;
        int         sz;
        int         nb0;
        logic [2:0] pg;
        logic [6:0] cl;
        logic [9:0] ad;
        logic [9:0] w;

        init_tab = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
                     8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                     8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        for (int i = 0; i < 25; i++) begin
            w = {2'b00, init_tab[i]};
            vecs.push_back('{name: "init_word", phase: 0, idx: i, exp: w});
        end
        // Flush transfer n: page p occupies indices p*131 .. p*131+130 (3 commands then 128 data)
        vecs.push_back('{name: "flush_p0_cmd0",  phase: 1, idx: 0,    exp: 10'h0B0});
        vecs.push_back('{name: "flush_p0_cmd1",  phase: 1, idx: 1,    exp: 10'h000});
        vecs.push_back('{name: "flush_p0_cmd2",  phase: 1, idx: 2,    exp: 10'h010});
        vecs.push_back('{name: "flush_p0_c0",    phase: 1, idx: 3,    exp: 10'h100});
        vecs.push_back('{name: "flush_p3_cmd0",  phase: 1, idx: 393,  exp: 10'h0B3});
        vecs.push_back('{name: "flush_p3_cmd1",  phase: 1, idx: 394,  exp: 10'h000});
        vecs.push_back('{name: "flush_p3_cmd2",  phase: 1, idx: 395,  exp: 10'h010});
        vecs.push_back('{name: "flush_p3_c5",    phase: 1, idx: 401,  exp: 10'h185});
        vecs.push_back('{name: "flush_p7_cmd0",  phase: 1, idx: 917,  exp: 10'h0B7});
        vecs.push_back('{name: "flush_p7_c127",  phase: 1, idx: 1047, exp: 10'h1FF});

        // Reset timing and init stream
        do_reset();
        lo = 0;
        hi = 0;
        @(negedge CLK);
        while (!OLED_RES && lo < 1000) begin
            lo++;
            @(negedge CLK);
        end
        while (OLED_RES && !SPI_START && hi < 1000) begin
            hi++;
            @(negedge CLK);
        end
        chk("res_low_cycles", lo, LOW);
        chk("res_wait_cycles_in_range", (hi >= WAIT && hi <= WAIT + 2) ? 1 : 0, 1);
        wait_init(5000);
        apply_vecs(0);
        chk("init_transfer_count", log_q.size(), 25);

        // Single flush from IDLE
        log_q.delete();
        done_cnt = 0;
        pulse_flush();
        wait_log(1048, 20000, "flush1");
        wait_idle(100, "flush1_idle");
        chk("flush1_done_at_idle", done_cnt, 1048);
        apply_vecs(1);
        bad = 0;
        for (int p = 0; p < 8; p++) begin
            pg = 3'(p);
            if (log_q.size() > p * 131 + 2) begin
                if (log_q[p * 131]     !== {2'b00, 5'b10110, pg}) bad++;
                if (log_q[p * 131 + 1] !== 10'h000) bad++;
                if (log_q[p * 131 + 2] !== 10'h010) bad++;
            end else bad++;
            for (int c = 0; c < 128; c++) begin
                cl = 7'(c);
                ad = {pg, cl};
                if (log_q.size() > p * 131 + 3 + c) begin
                    if (log_q[p * 131 + 3 + c] !== {2'b01, ad[7:0]}) bad++;
                end else bad++;
            end
        end
        chk("flush1_all_words_bad", bad, 0);
        repeat (30) @(negedge CLK);
        chk("flush1_no_extra", log_q.size(), 1048);

        // Spurious DONE in IDLE
        sz = log_q.size();
        @(negedge CLK);
        force_done = 1'b1;
        @(negedge CLK);
        force_done = 1'b0;
        repeat (20) @(negedge CLK);
        chk("spurious_done_no_start", log_q.size(), sz);
        chk("spurious_done_busy", BUSY, 0);
        chk("spurious_done_init_done", INIT_DONE, 1);

        // FLUSH during INIT and twice during a flush
        do_reset();
        wait_log(5, 1000, "pend_init");
        pulse_flush();
        wait_log(25 + 500, 40000, "pend_a");
        pulse_flush();
        wait_log(25 + 900, 40000, "pend_b");
        pulse_flush();
        wait_log(25 + 2096, 40000, "pend_c");
        wait_idle(100, "pend_idle");
        repeat (100) @(negedge CLK);
        chk("pend_total_transfers", log_q.size(), 25 + 2096);
        nb0 = 0;
        for (int i = 0; i < log_q.size(); i++) if (log_q[i] === 10'h0B0) nb0++;
        chk("pend_refresh_count", nb0, 2);
        chk("pend_busy_end", BUSY, 0);

        // Slow SPI: 40-cycle DONE latency through init
        lat = 40;
        do_reset();
        wait_init(5000);
        apply_vecs(0);

        // Reset while page 2 data is streaming
        lat = 5;
        log_q.delete();
        pulse_flush();
        wait_log(25 + 2 * 131 + 10, 10000, "mid_flush");
        do_reset();
        wait_log(3, 500, "reinit");
        chk("reinit_word0", (log_q.size() > 0) ? {22'd0, log_q[0]} : 32'hFFFF_FFFF, 32'h0AE);
        chk("reinit_word1", (log_q.size() > 1) ? {22'd0, log_q[1]} : 32'hFFFF_FFFF, 32'h0D5);
        chk("reinit_word2", (log_q.size() > 2) ? {22'd0, log_q[2]} : 32'hFFFF_FFFF, 32'h080);

        chk("spi_data_stable_errors", stab_err, 0);
        chk("spi_start_protocol_errors", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
